// File: rtl/mpx_wb_arbiter.sv
// Write-port arbiter for the 2R/1W register file: merges ALU, LSU and MUL
// results onto one registered write port and tracks pending long-latency writes.
module mpx_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_value_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_value_i,
  output logic        lsu_accept_o,
  input  logic        mul_valid_i,
  input  logic [4:0]  mul_rd_i,
  input  logic [31:0] mul_value_i,
  output logic        mul_accept_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic        ra_busy_o,
  output logic        rb_busy_o,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU,
    SRC_MUL
  } src_e;

  src_e              grant;
  logic              mul_prio;
  logic [CNT_W-1:0]  starve_q;
  logic [4:0]        win_rd;
  logic [31:0]       win_value;
  logic              rd0_long_q;
  logic [4:0]        rd0_q;
  logic [31:0]       rd0_value_q;
  logic [31:0]       pending_q;
  logic [31:0]       pending_d;

  assign mul_prio = (starve_q >= CNT_W'(STARVE_LIMIT));

  // ALU always wins; MUL overtakes LSU only once it has been starved long enough.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = SRC_NONE;
    if (alu_valid_i)                                 grant = SRC_ALU;
    else if (mul_valid_i && (mul_prio || !lsu_valid_i)) grant = SRC_MUL;
    else if (lsu_valid_i)                            grant = SRC_LSU;
  end

  assign lsu_accept_o = rst_i && (grant == SRC_LSU);
  assign mul_accept_o = rst_i && (grant == SRC_MUL);

  always_comb begin
    win_rd    = '0;
    win_value = '0;
    unique case (grant)
      SRC_ALU: begin win_rd = alu_rd_i; win_value = alu_value_i; end
      SRC_LSU: begin win_rd = lsu_rd_i; win_value = lsu_value_i; end
      SRC_MUL: begin win_rd = mul_rd_i; win_value = mul_value_i; end
      default: ;
    endcase
  end

  // A same-cycle issue to the register being retired must leave it pending.
  always_comb begin
    pending_d = pending_q;
    if (rd0_long_q) pending_d[rd0_q] = 1'b0;
    if (issue_valid_i && (issue_rd_i != 5'd0)) pending_d[issue_rd_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_q    <= '0;
      rd0_q       <= '0;
      rd0_value_q <= '0;
      rd0_long_q  <= 1'b0;
      pending_q   <= '0;
    end else begin
      if (grant == SRC_MUL)
        starve_q <= '0;
      else if (mul_valid_i && (starve_q != {CNT_W{1'b1}}))
        starve_q <= starve_q + 1'b1;

      if (grant != SRC_NONE) begin
        rd0_q       <= win_rd;
        rd0_value_q <= win_value;
        rd0_long_q  <= (grant == SRC_LSU) || (grant == SRC_MUL);
      end else begin
        rd0_q      <= '0;
        rd0_long_q <= 1'b0;
      end

      pending_q <= pending_d;
    end
  end

  assign rd0_o       = rd0_q;
  assign rd0_value_o = rd0_value_q;
  assign ra_busy_o   = pending_q[ra_i] && (ra_i != 5'd0);
  assign rb_busy_o   = pending_q[rb_i] && (rb_i != 5'd0);

endmodule

// File: tb/tb_mpx_wb_arbiter.sv
// Directed bench for mpx_wb_arbiter: grant order, starvation, scoreboard
// set/clear, and asynchronous reset.
module tb_mpx_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i, mul_valid_i, issue_valid_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, mul_rd_i, issue_rd_i, ra_i, rb_i;
  logic [31:0] alu_value_i, lsu_value_i, mul_value_i;
  logic        lsu_accept_o, mul_accept_o, ra_busy_o, rb_busy_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  mpx_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_value_i(alu_value_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_value_i(lsu_value_i),
    .lsu_accept_o(lsu_accept_o),
    .mul_valid_i(mul_valid_i), .mul_rd_i(mul_rd_i), .mul_value_i(mul_value_i),
    .mul_accept_o(mul_accept_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .ra_i(ra_i), .rb_i(rb_i), .ra_busy_o(ra_busy_o), .rb_busy_o(rb_busy_o),
    .rd0_o(rd0_o), .rd0_value_o(rd0_value_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] val);
    check({tag, "_rd"}, 32'(rd0_o), 32'(rd));
    check({tag, "_val"}, rd0_value_o, val);
  endtask

  task automatic check_acc(input string tag, input logic lsu, input logic mul);
    check({tag, "_lsu_acc"}, 32'(lsu_accept_o), 32'(lsu));
    check({tag, "_mul_acc"}, 32'(mul_accept_o), 32'(mul));
  endtask

  initial begin
    rst_i = 1'b0;
    alu_valid_i = 0; lsu_valid_i = 0; mul_valid_i = 0; issue_valid_i = 0;
    alu_rd_i = 0; lsu_rd_i = 0; mul_rd_i = 0; issue_rd_i = 0; ra_i = 0; rb_i = 0;
    alu_value_i = 0; lsu_value_i = 0; mul_value_i = 0;

    // Reset state: accepts forced low even with sources valid.
    #2;
    lsu_valid_i = 1; mul_valid_i = 1;
    #1;
    check_wr("reset", 5'd0, 32'h0);
    check_acc("reset", 1'b0, 1'b0);
    lsu_valid_i = 0; mul_valid_i = 0;
    #9 rst_i = 1'b1;
    tick();

    // ALU only.
    alu_valid_i = 1; alu_rd_i = 5'd5; alu_value_i = 32'h1234;
    tick();
    alu_valid_i = 0;
    #1 check_wr("alu_only", 5'd5, 32'h1234);
    tick();
    check_wr("alu_idle", 5'd0, 32'h1234);

    // Contention: ALU, then LSU, then MUL.
    alu_valid_i = 1; alu_rd_i = 5'd1; alu_value_i = 32'hA;
    lsu_valid_i = 1; lsu_rd_i = 5'd3; lsu_value_i = 32'hB;
    mul_valid_i = 1; mul_rd_i = 5'd4; mul_value_i = 32'hC;
    #1 check_acc("cont_c0", 1'b0, 1'b0);
    tick();
    alu_valid_i = 0;
    #1 check_acc("cont_c1", 1'b1, 1'b0);
    check_wr("cont_alu", 5'd1, 32'hA);
    tick();
    lsu_valid_i = 0;
    #1 check_acc("cont_c2", 1'b0, 1'b1);
    check_wr("cont_lsu", 5'd3, 32'hB);
    tick();
    mul_valid_i = 0;
    #1 check_wr("cont_mul", 5'd4, 32'hC);
    tick();

    // Starvation: MUL refused four cycles, wins on the fifth.
    lsu_valid_i = 1; lsu_rd_i = 5'd6; lsu_value_i = 32'h600;
    mul_valid_i = 1; mul_rd_i = 5'd7; mul_value_i = 32'h700;
    for (int k = 0; k < 4; k++) begin
      #1 check_acc($sformatf("starve_c%0d", k), 1'b1, 1'b0);
      tick();
    end
    #1 check_acc("starve_c4", 1'b0, 1'b1);
    check_wr("starve_lsu", 5'd6, 32'h600);
    tick();
    mul_rd_i = 5'd8; mul_value_i = 32'h800;
    #1 check_wr("starve_mul", 5'd7, 32'h700);
    check_acc("starve_cleared", 1'b1, 1'b0);
    tick();
    lsu_valid_i = 0; mul_valid_i = 0;
    #1 check_wr("starve_tail", 5'd6, 32'h600);
    tick();

    // Scoreboard: busy from issue until the cycle after the LSU write of r9.
    issue_valid_i = 1; issue_rd_i = 5'd9; ra_i = 5'd9; rb_i = 5'd0;
    #1 check("sb_not_yet", 32'(ra_busy_o), 32'd0);
    tick();
    issue_valid_i = 0;
    #1 check("sb_set", 32'(ra_busy_o), 32'd1);
    check("sb_r0", 32'(rb_busy_o), 32'd0);
    tick();
    lsu_valid_i = 1; lsu_rd_i = 5'd9; lsu_value_i = 32'h900;
    #1 check("sb_held", 32'(ra_busy_o), 32'd1);
    check_acc("sb_lsu", 1'b1, 1'b0);
    tick();
    lsu_valid_i = 0;
    #1 check_wr("sb_write", 5'd9, 32'h900);
    check("sb_during_write", 32'(ra_busy_o), 32'd1);
    tick();
    check("sb_cleared", 32'(ra_busy_o), 32'd0);

    // ALU write to a pending register leaves it pending.
    issue_valid_i = 1; issue_rd_i = 5'd12; rb_i = 5'd12;
    tick();
    issue_valid_i = 0;
    alu_valid_i = 1; alu_rd_i = 5'd12; alu_value_i = 32'hC0C;
    tick();
    alu_valid_i = 0;
    #1 check_wr("alu_pend_wr", 5'd12, 32'hC0C);
    tick();
    check("alu_pend_kept", 32'(rb_busy_o), 32'd1);

    // Set/clear collision on r9: set wins.
    issue_valid_i = 1; issue_rd_i = 5'd9;
    tick();
    issue_valid_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 5'd9; lsu_value_i = 32'h901;
    tick();
    lsu_valid_i = 0;
    issue_valid_i = 1; issue_rd_i = 5'd9;
    #1 check_wr("coll_write", 5'd9, 32'h901);
    tick();
    issue_valid_i = 0;
    #1 check("coll_set_wins", 32'(ra_busy_o), 32'd1);
    tick();
    check("coll_still", 32'(ra_busy_o), 32'd1);

    // Async reset with pending r2/r9/r12 and rd0_o=9 in flight.
    issue_valid_i = 1; issue_rd_i = 5'd2;
    tick();
    issue_valid_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 5'd9; lsu_value_i = 32'h902;
    tick();
    rb_i = 5'd2;
    #1 check_wr("pre_rst", 5'd9, 32'h902);
    check("pre_rst_r2", 32'(rb_busy_o), 32'd1);
    #1 rst_i = 1'b0;
    #1 check_wr("rst_async", 5'd0, 32'h0);
    check("rst_ra", 32'(ra_busy_o), 32'd0);
    check("rst_rb", 32'(rb_busy_o), 32'd0);
    check_acc("rst_acc", 1'b0, 1'b0);
    rb_i = 5'd12;
    #1 check("rst_r12", 32'(rb_busy_o), 32'd0);
    lsu_valid_i = 0;
    #3 rst_i = 1'b1;
    tick();
    check("post_rst_ra", 32'(ra_busy_o), 32'd0);
    check_wr("post_rst", 5'd0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
